id_ex_alu_stage: RTL

//   ID/EX pipeline stage directly upstream of ALU_32b. Registers decoded instruction fields,

---
 rtl/id_ex_alu_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register feeding ALU_32b: decodes the ALU operation at capture,
// forwards EX/MEM and MEM/WB results into the operands, and flags load-use hazards.
module id_ex_alu_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [1:0]        in_alu_op,
    input  logic [5:0]        in_funct,
    input  logic              in_alu_src,
    input  logic              in_reg_dst,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_mem_to_reg,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              exmem_reg_write,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [3:0]        operation,
    output logic [DATA_W-1:0] data_0,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] store_data,
    output logic              out_valid,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_mem_to_reg,
    output logic              illegal_op,
    output logic              load_use_hazard
);

    // Returns {illegal, op[3:0]}; unsupported R-type funct falls back to add.
    function automatic logic [4:0] alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
        logic [4:0] res;
        res = 5'b0_0010;
        case (alu_op)
            2'b00: res = 5'b0_0010;
            2'b01: res = 5'b0_0110;
            2'b11: res = 5'b0_0001;
            default: begin
                case (funct)
                    6'b100000: res = 5'b0_0010;
                    6'b100010: res = 5'b0_0110;
                    6'b100100: res = 5'b0_0000;
                    6'b100101: res = 5'b0_0001;
                    6'b101010: res = 5'b0_0111;
                    6'b100111: res = 5'b0_1100;
                    default:   res = 5'b1_0010;
                endcase
            end
        endcase
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] forward(
        input logic              en,
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] file_val,
        input logic              ex_we,
        input logic [REG_AW-1:0] ex_rd,
        input logic [DATA_W-1:0] ex_val,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_val
    );
        logic [DATA_W-1:0] res;
        res = file_val;
        if (en && ex_we && (ex_rd != '0) && (ex_rd == src))
            res = ex_val;
        else if (en && wb_we && (wb_rd != '0) && (wb_rd == src))
            res = wb_val;
        return res;
    endfunction

    logic              r_valid;
    logic [3:0]        r_op;
    logic              r_illegal;
    logic              r_alu_src;
    logic [REG_AW-1:0] r_dest;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;

    logic [4:0]        w_dec;
    logic              w_bubble;
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;

    assign w_dec    = alu_decode(in_alu_op, in_funct);
    // Flush beats stall; an empty decode slot only becomes a bubble when not stalled.
    assign w_bubble = flush || (!stall && !in_valid);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= 1'b0;
            r_op         <= '0;
            r_illegal    <= 1'b0;
            r_alu_src    <= 1'b0;
            r_dest       <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
        end else if (w_bubble) begin
            r_valid      <= 1'b0;
            r_illegal    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!stall) begin
            r_valid      <= 1'b1;
            r_op         <= w_dec[3:0];
            r_illegal    <= w_dec[4];
            r_alu_src    <= in_alu_src;
            r_dest       <= in_reg_dst ? in_rd : in_rt;
            r_reg_write  <= in_reg_write;
            r_mem_read   <= in_mem_read;
            r_mem_write  <= in_mem_write;
            r_mem_to_reg <= in_mem_to_reg;
            r_rs         <= in_rs;
            r_rt         <= in_rt;
            r_rs_data    <= in_rs_data;
            r_rt_data    <= in_rt_data;
            r_imm        <= in_imm;
        end
    end

    // EX stage: combinational operand forwarding
    assign w_fwd_a = forward(r_valid, r_rs, r_rs_data, exmem_reg_write, exmem_rd, exmem_result,
                             memwb_reg_write, memwb_rd, memwb_result);
    assign w_fwd_b = forward(r_valid, r_rt, r_rt_data, exmem_reg_write, exmem_rd, exmem_result,
                             memwb_reg_write, memwb_rd, memwb_result);

    assign data_0         = w_fwd_a;
    assign store_data     = w_fwd_b;
    assign data_1         = r_alu_src ? r_imm : w_fwd_b;
    assign operation      = r_op;
    assign out_valid      = r_valid;
    assign out_dest       = r_dest;
    assign out_reg_write  = r_reg_write;
    assign out_mem_read   = r_mem_read;
    assign out_mem_write  = r_mem_write;
    assign out_mem_to_reg = r_mem_to_reg;
    assign illegal_op     = r_illegal;

    assign load_use_hazard = r_valid && r_mem_read && (r_dest != '0) && in_valid &&
                             ((r_dest == in_rs) || (r_dest == in_rt));

endmodule
